// File: rtl/baud_tick_gen_frac_if.sv
// Control and tick bundle between a baud tick generator and the UART shifters it paces.
// The master drives rate/enable/re-phase controls; the slave returns the tick strobes.
interface baud_tick_gen_frac_if #(
    parameter int ACC_W = 16,
    parameter int OS_W  = 3
);
    logic             enable;
    logic             restart;
    logic [ACC_W-1:0] inc;
    logic             inc_load;
    logic             tick_os;
    logic             tick_bit;
    logic             tick_mid;
    logic [OS_W-1:0]  os_phase;

    modport master (
        output enable, restart, inc, inc_load,
        input  tick_os, tick_bit, tick_mid, os_phase
    );

    modport slave (
        input  enable, restart, inc, inc_load,
        output tick_os, tick_bit, tick_mid, os_phase
    );
endinterface

// File: rtl/baud_tick_gen_frac.sv
// Phase-accumulator UART baud tick generator: tick_os at OVERSAMPLE x baud, tick_bit at baud.
// Latency: ticks are registered, high the cycle after the overflowing edge; no backpressure.
// Optional mid-bit strobe (tick_mid) is built only when BAUD_TICK_GEN_MIDBIT_EN is defined.
module baud_tick_gen_frac #(
    parameter int               ACC_W      = 16,
    parameter int               OVERSAMPLE = 8,
    parameter logic [ACC_W-1:0] INC_RST    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    baud_tick_gen_frac_if.slave  bus
);
    localparam int               OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [ACC_W-1:0] ACC_HALF = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_r;
    logic [OS_W-1:0]  os_cnt;
    logic             tick_os;
    logic             tick_bit;
    logic [ACC_W:0]   sum;
    logic             carry;

    assign sum   = {1'b0, acc} + {1'b0, inc_r};
    assign carry = sum[ACC_W];

    // Rate register is independent of enable/restart so software can reprogram while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_r <= INC_RST;
        end else if (bus.inc_load) begin
            inc_r <= bus.inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
        end else if (!bus.enable) begin
            acc      <= '0;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
        end else if (bus.restart) begin
            // Half-full accumulator puts the next carry half an oversample period away.
            acc      <= ACC_HALF;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
        end else begin
            acc      <= sum[ACC_W-1:0];
            tick_os  <= carry;
            tick_bit <= carry && (os_cnt == OS_LAST);
            if (carry) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end
        end
    end

    assign bus.tick_os  = tick_os;
    assign bus.tick_bit = tick_bit;
    assign bus.os_phase = os_cnt;

`ifdef BAUD_TICK_GEN_MIDBIT_EN
    localparam logic [OS_W-1:0] OS_PRE_MID = OS_W'(OVERSAMPLE / 2 - 1);

    logic tick_mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_mid <= 1'b0;
        end else if (!bus.enable || bus.restart) begin
            tick_mid <= 1'b0;
        end else begin
            tick_mid <= carry && (os_cnt == OS_PRE_MID);
        end
    end

    assign bus.tick_mid = tick_mid;
`else
    assign bus.tick_mid = 1'b0;
`endif
endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Directed bench for baud_tick_gen_frac at ACC_W=16, OVERSAMPLE=4, INC_RST=0.
module tb_baud_tick_gen_frac;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    baud_tick_gen_frac_if #(.ACC_W(16), .OS_W(2)) bif ();

    baud_tick_gen_frac #(
        .ACC_W      (16),
        .OVERSAMPLE (4),
        .INC_RST    (16'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One disabled edge clears acc/os_cnt while loading the rate; next edge is enabled edge 1.
    task automatic clear_and_load(input logic [15:0] v);
        bif.enable   = 1'b0;
        bif.restart  = 1'b0;
        bif.inc      = v;
        bif.inc_load = 1'b1;
        step();
        bif.inc_load = 1'b0;
        bif.enable   = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            got = {bif.tick_os, bif.tick_bit, bif.tick_mid, bif.os_phase};
            checks++;
            if (got !== 5'b0) begin
                fails++;
                $display("FAIL reset_outputs i=%0d got %b expected 00000", i, got);
            end
            step();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        logic [3:0] got, exp;
        clear_and_load(16'h4000);
        for (int k = 1; k <= 48; k++) begin
            step();
            got = {bif.tick_os, bif.tick_bit, bif.os_phase};
            exp = {(k % 4 == 0), (k % 16 == 0), 2'((k / 4) % 4)};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL nominal edge=%0d got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_midbit();
        logic exp;
        clear_and_load(16'h4000);
        for (int k = 1; k <= 40; k++) begin
            step();
`ifdef BAUD_TICK_GEN_MIDBIT_EN
            exp = (k % 16 == 8);
`else
            exp = 1'b0;
`endif
            checks++;
            if (bif.tick_mid !== exp) begin
                fails++;
                $display("FAIL midbit edge=%0d got %b expected %b", k, bif.tick_mid, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        logic       t;
        int         cnt;
        cnt = 0;
        clear_and_load(16'hC000);
        for (int k = 1; k <= 12; k++) begin
            step();
            t = (k % 4 != 1);
            if (t) cnt++;
            exp = {t, t && (cnt % 4 == 0), 2'(cnt % 4)};
            got = {bif.tick_os, bif.tick_bit, bif.os_phase};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL back_to_back edge=%0d got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_restart();
        logic [3:0] got;
        clear_and_load(16'h4000);
        repeat (4) step();
        got = {bif.tick_os, bif.tick_bit, bif.os_phase};
        checks++;
        if (got !== 4'b1001) begin
            fails++;
            $display("FAIL restart_pre got %b expected 1001", got);
        end
        bif.restart = 1'b1;
        step();
        bif.restart = 1'b0;
        got = {bif.tick_os, bif.tick_bit, bif.os_phase};
        checks++;
        if (got !== 4'b0000) begin
            fails++;
            $display("FAIL restart_edge got %b expected 0000", got);
        end
        step();
        checks++;
        if (bif.tick_os !== 1'b0) begin
            fails++;
            $display("FAIL restart_plus1 got %b expected 0", bif.tick_os);
        end
        step();
        got = {bif.tick_os, bif.tick_bit, bif.os_phase};
        checks++;
        if (got !== 4'b1001) begin
            fails++;
            $display("FAIL restart_plus2 got %b expected 1001", got);
        end
        // enable=0 must win over restart: acc restarts from 0, so first tick is 4 edges out.
        bif.enable  = 1'b0;
        bif.restart = 1'b1;
        step();
        bif.enable  = 1'b1;
        bif.restart = 1'b0;
        step();
        step();
        checks++;
        if (bif.tick_os !== 1'b0) begin
            fails++;
            $display("FAIL restart_priority_e2 got %b expected 0", bif.tick_os);
        end
        step();
        step();
        checks++;
        if (bif.tick_os !== 1'b1) begin
            fails++;
            $display("FAIL restart_priority_e4 got %b expected 1", bif.tick_os);
        end
    endtask

    task automatic test_inc_change();
        logic [3:0] got, exp;
        clear_and_load(16'h4000);
        repeat (6) step();
        bif.inc      = 16'h8000;
        bif.inc_load = 1'b1;
        step();
        bif.inc_load = 1'b0;
        checks++;
        if (bif.tick_os !== 1'b0) begin
            fails++;
            $display("FAIL inc_change_load_edge got %b expected 0", bif.tick_os);
        end
        for (int k = 8; k <= 14; k++) begin
            step();
            exp = {(k % 2 == 0), (k == 12), 2'(((k - 8) / 2 + 2) % 4)};
            got = {bif.tick_os, bif.tick_bit, bif.os_phase};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL inc_change edge=%0d got %b expected %b", k, got, exp);
            end
        end
        bif.enable = 1'b0;
        for (int k = 15; k <= 16; k++) begin
            step();
            got = {bif.tick_os, bif.tick_bit, bif.os_phase};
            checks++;
            if (got !== 4'b0000) begin
                fails++;
                $display("FAIL inc_change_disabled edge=%0d got %b expected 0000", k, got);
            end
        end
        bif.enable = 1'b1;
        step();
        checks++;
        if (bif.tick_os !== 1'b0) begin
            fails++;
            $display("FAIL inc_change_reenable_e1 got %b expected 0", bif.tick_os);
        end
        step();
        got = {bif.tick_os, bif.tick_bit, bif.os_phase};
        checks++;
        if (got !== 4'b1001) begin
            fails++;
            $display("FAIL inc_change_reenable_e2 got %b expected 1001", got);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] got;
        int         n;
        clear_and_load(16'h4000);
        repeat (20) step();
        got = {bif.tick_os, bif.tick_bit, bif.tick_mid, bif.os_phase};
        checks++;
        if (got[4] !== 1'b1 || got[1:0] !== 2'd1) begin
            fails++;
            $display("FAIL async_reset_pre got %b expected tick_os=1 os_phase=1", got);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bif.tick_os, bif.tick_bit, bif.tick_mid, bif.os_phase};
        checks++;
        if (got !== 5'b0) begin
            fails++;
            $display("FAIL async_reset_drop got %b expected 00000", got);
        end
        step();
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (bif.tick_os !== 1'b0 || bif.tick_bit !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin
            fails++;
            $display("FAIL async_reset_inc_rst ticks got %0d expected 0", n);
        end
    endtask

    task automatic test_long_run();
        int n_os, n_bit, last, bad_gap, first_bad, orphan_bit;
        n_os = 0; n_bit = 0; last = -1; bad_gap = 0; first_bad = 0; orphan_bit = 0;
        clear_and_load(16'd10000);
        for (int k = 1; k <= 65536; k++) begin
            step();
            if (bif.tick_os === 1'b1) begin
                if (last >= 0 && (k - last) != 6 && (k - last) != 7) begin
                    if (bad_gap == 0) first_bad = k - last;
                    bad_gap++;
                end
                last = k;
                n_os++;
            end
            if (bif.tick_bit === 1'b1) begin
                n_bit++;
                if (bif.tick_os !== 1'b1) orphan_bit++;
            end
        end
        checks++;
        if (n_os != 10000) begin
            fails++;
            $display("FAIL long_run_tick_os count got %0d expected 10000", n_os);
        end
        checks++;
        if (n_bit != 2500) begin
            fails++;
            $display("FAIL long_run_tick_bit count got %0d expected 2500", n_bit);
        end
        checks++;
        if (bad_gap != 0) begin
            fails++;
            $display("FAIL long_run_gap bad=%0d first gap got %0d expected 6 or 7", bad_gap, first_bad);
        end
        checks++;
        if (orphan_bit != 0) begin
            fails++;
            $display("FAIL long_run_bit_align got %0d lone tick_bit expected 0", orphan_bit);
        end
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        rst_n        = 1'b1;
        bif.enable   = 1'b0;
        bif.restart  = 1'b0;
        bif.inc      = 16'h0;
        bif.inc_load = 1'b0;
        test_reset();
        test_nominal();
        test_midbit();
        test_back_to_back();
        test_restart();
        test_inc_change();
        test_async_reset();
        test_long_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
